board_mem_arbiter: RTL and testbench

//  Owns the single-port board RAM: 20 rows x 10 cells, each cell a 16-bit colour word.

---
 rtl/board_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_board_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: video row prefetch (strict priority) into a
// double-buffered Row bank, game-logic cell accesses when the port is free.
module board_mem_arbiter #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int DW   = 16,
    parameter int AW   = 8
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     LD_Row,
    input  logic [7:0]               rowNum,
    output logic [COLS-1:0][DW-1:0]  Row,
    output logic                     rowReady,
    input  logic                     g_req,
    input  logic                     g_we,
    input  logic [4:0]               g_row,
    input  logic [3:0]               g_col,
    input  logic [DW-1:0]            g_wdata,
    output logic                     g_gnt,
    output logic                     g_rvalid,
    output logic [DW-1:0]            g_rdata,
    output logic [AW-1:0]            mem_addr,
    output logic                     mem_we,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata
);

    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {IDLE, V_ARM, V_FETCH, V_LAST} state_t;

    state_t                    state;
    logic                      ld_q;
    logic                      ld_rise;
    logic [7:0]                fetch_row;
    logic                      fetch_oor;
    logic [7:0]                pend_row;
    logic                      pend;
    logic [CW-1:0]             col;
    logic [COLS-1:0][DW-1:0]   shadow;
    logic                      g_oor;
    logic                      rd_oor;
    logic [AW-1:0]             video_addr;
    logic [AW-1:0]             game_addr;

    assign ld_rise    = LD_Row & ~ld_q;
    assign g_oor      = (int'(g_row) >= ROWS) || (int'(g_col) >= COLS);
    assign video_addr = AW'(fetch_row) * AW'(COLS) + AW'(col);
    assign game_addr  = AW'(g_row) * AW'(COLS) + AW'(g_col);

    // The game port only sees the RAM in an IDLE cycle with no video work queued.
    assign g_gnt     = (state == IDLE) && !ld_rise && !pend && g_req;
    assign mem_wdata = g_wdata;

    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        if (state == V_FETCH) begin
            mem_addr = video_addr;
        end else if (g_gnt) begin
            mem_addr = game_addr;
            mem_we   = g_we && !g_oor;
        end
    end

    // RAM data for a game read arrives the cycle after the grant.
    assign g_rdata = (g_rvalid && !rd_oor) ? mem_rdata : '0;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            ld_q      <= 1'b0;
            fetch_row <= '0;
            fetch_oor <= 1'b0;
            pend_row  <= '0;
            pend      <= 1'b0;
            col       <= '0;
            shadow    <= '0;
            Row       <= '0;
            rowReady  <= 1'b0;
            g_rvalid  <= 1'b0;
            rd_oor    <= 1'b0;
        end else begin
            ld_q     <= LD_Row;
            rowReady <= (state == V_LAST);
            g_rvalid <= g_gnt && !g_we;
            rd_oor   <= g_oor;

            // Any request arriving while busy parks here; newest one wins.
            if (state != IDLE && ld_rise) begin
                pend     <= 1'b1;
                pend_row <= rowNum;
            end

            case (state)
                IDLE: begin
                    if (ld_rise) begin
                        fetch_row <= rowNum;
                        pend      <= 1'b0;
                        col       <= '0;
                        fetch_oor <= (int'(rowNum) >= ROWS);
                        state     <= (int'(rowNum) >= ROWS) ? V_LAST : V_FETCH;
                    end else if (pend) begin
                        fetch_row <= pend_row;
                        pend      <= 1'b0;
                        state     <= V_ARM;
                    end
                end
                V_ARM: begin
                    col       <= '0;
                    fetch_oor <= (int'(fetch_row) >= ROWS);
                    state     <= (int'(fetch_row) >= ROWS) ? V_LAST : V_FETCH;
                end
                V_FETCH: begin
                    if (col != '0)
                        shadow[col - 1'b1] <= mem_rdata;
                    col <= col + 1'b1;
                    if (col == CW'(COLS - 1))
                        state <= V_LAST;
                end
                V_LAST: begin
                    shadow[COLS-1] <= mem_rdata;
                    for (int i = 0; i < COLS; i++) begin
                        if (fetch_oor)
                            Row[i] <= '0;
                        else if (i == COLS - 1)
                            Row[i] <= mem_rdata;
                        else
                            Row[i] <= shadow[i];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: board RAM model plus a reference array of the
// board contents; rows and reads are predicted from that array and the timing rules.
module tb_board_mem_arbiter;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int DW   = 16;
    localparam int AW   = 8;

    logic                    Clk = 1'b0;
    logic                    reset;
    logic                    LD_Row;
    logic [7:0]              rowNum;
    logic [COLS-1:0][DW-1:0] Row;
    logic                    rowReady;
    logic                    g_req, g_we;
    logic [4:0]              g_row;
    logic [3:0]              g_col;
    logic [DW-1:0]           g_wdata;
    logic                    g_gnt, g_rvalid;
    logic [DW-1:0]           g_rdata;
    logic [AW-1:0]           mem_addr;
    logic                    mem_we;
    logic [DW-1:0]           mem_wdata;
    logic [DW-1:0]           mem_rdata;

    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ref_mem [0:ROWS-1][0:COLS-1];
    logic          load_ram;

    int checks   = 0;
    int failures = 0;

    board_mem_arbiter #(.COLS(COLS), .ROWS(ROWS), .DW(DW), .AW(AW)) dut (
        .Clk(Clk), .reset(reset), .LD_Row(LD_Row), .rowNum(rowNum), .Row(Row),
        .rowReady(rowReady), .g_req(g_req), .g_we(g_we), .g_row(g_row), .g_col(g_col),
        .g_wdata(g_wdata), .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Board RAM: synchronous read, one cycle latency, read-before-write.
    always @(posedge Clk) begin
        if (load_ram) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= (i < ROWS * COLS) ? {8'(i / COLS), 8'(i % COLS)} : 16'h0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [COLS-1:0][DW-1:0] exp_row(input int r);
        logic [COLS-1:0][DW-1:0] v;
        v = '0;
        if (r < ROWS)
            for (int c = 0; c < COLS; c++) v[c] = ref_mem[r][c];
        return v;
    endfunction

    task automatic do_fetch(input int r, output int lat, output logic addr_ok);
        @(negedge Clk);
        LD_Row = 1'b1;
        rowNum = r[7:0];
        lat = -1;
        addr_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (k == 1) LD_Row = 1'b0;
            if (r < ROWS && k <= COLS && mem_addr !== AW'(r * COLS + k - 1)) addr_ok = 1'b0;
            if (int'(mem_addr) >= ROWS * COLS) addr_ok = 1'b0;
            if (rowReady === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_game(input logic we, input int r, input int c, input logic [DW-1:0] d,
                           output int wt, output logic rv, output logic [DW-1:0] rd);
        @(negedge Clk);
        g_req = 1'b1; g_we = we; g_row = r[4:0]; g_col = c[3:0]; g_wdata = d;
        wt = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (g_gnt === 1'b1) begin
                wt = k;
                break;
            end
            @(negedge Clk);
        end
        @(negedge Clk);
        g_req = 1'b0;
        rv = g_rvalid;
        rd = g_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_ram = 1'b1;
        repeat (3) @(negedge Clk);
        reset = 1'b0; load_ram = 1'b0;
        @(negedge Clk);
        checks++; if (Row !== '0) begin failures++; $display("FAIL reset_row: got %h want 0", Row); end
        checks++; if (rowReady !== 1'b0) begin failures++; $display("FAIL reset_rowready: got %b want 0", rowReady); end
        checks++; if (g_rvalid !== 1'b0 || g_rdata !== '0) begin failures++; $display("FAIL reset_game: rvalid %b rdata %h want 0/0", g_rvalid, g_rdata); end
        checks++; if (mem_we !== 1'b0 || g_gnt !== 1'b0) begin failures++; $display("FAIL reset_mem: we %b gnt %b want 0/0", mem_we, g_gnt); end
    endtask

    task automatic test_row_fetch();
        int lat; logic ok;
        do_fetch(3, lat, ok);
        checks++; if (lat !== 12) begin failures++; $display("FAIL fetch_latency: got %0d want 12", lat); end
        checks++; if (Row !== exp_row(3)) begin failures++; $display("FAIL fetch_row3: got %h want %h", Row, exp_row(3)); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fetch_addr: address sequence wrong, got %b want 1", ok); end
        @(negedge Clk);
        checks++; if (rowReady !== 1'b0) begin failures++; $display("FAIL fetch_pulse: got %b want 0", rowReady); end
    endtask

    task automatic test_hold();
        int pulses = 0; int first = -1;
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'd8;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            if (k == 5) LD_Row = 1'b0;
            if (rowReady === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        checks++; if (first !== 12) begin failures++; $display("FAIL hold_latency: got %0d want 12", first); end
        checks++; if (Row !== exp_row(8)) begin failures++; $display("FAIL hold_row8: got %h want %h", Row, exp_row(8)); end
    endtask

    task automatic test_game_rw();
        int wt; logic rv; logic [DW-1:0] rd;
        @(negedge Clk);
        g_req = 1'b1; g_we = 1'b1; g_row = 5'd19; g_col = 4'd9; g_wdata = 16'h0ABC;
        #1;
        checks++; if (g_gnt !== 1'b1 || mem_addr !== 8'd199 || mem_we !== 1'b1)
            begin failures++; $display("FAIL game_write: gnt %b addr %0d we %b want 1/199/1", g_gnt, mem_addr, mem_we); end
        @(negedge Clk);
        g_req = 1'b0;
        ref_mem[19][9] = 16'h0ABC;
        do_game(1'b0, 19, 9, 16'h0, wt, rv, rd);
        checks++; if (wt !== 0) begin failures++; $display("FAIL game_read_gnt: wait %0d want 0", wt); end
        checks++; if (rv !== 1'b1 || rd !== 16'h0ABC) begin failures++; $display("FAIL game_read: rvalid %b rdata %h want 1/0abc", rv, rd); end
        // Out-of-range cell: granted, no write, read returns 0.
        @(negedge Clk);
        g_req = 1'b1; g_we = 1'b1; g_row = 5'd25; g_col = 4'd2; g_wdata = 16'hDEAD;
        #1;
        checks++; if (g_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL game_oor_write: gnt %b we %b want 1/0", g_gnt, mem_we); end
        @(negedge Clk);
        g_req = 1'b0;
        do_game(1'b0, 3, 12, 16'h0, wt, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 16'h0) begin failures++; $display("FAIL game_oor_read: rvalid %b rdata %h want 1/0", rv, rd); end
    endtask

    task automatic test_collision();
        int gnt_at = -1; logic we_early = 1'b0; logic ok_at_gnt = 1'b0;
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'd7;
        g_req = 1'b1; g_we = 1'b1; g_row = 5'd2; g_col = 4'd4; g_wdata = 16'h1234;
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == 1) LD_Row = 1'b0;
            #1;
            if (g_gnt === 1'b1) begin
                gnt_at = k;
                ok_at_gnt = (mem_we === 1'b1) && (mem_addr === 8'd24);
                break;
            end
            if (mem_we !== 1'b0) we_early = 1'b1;
        end
        @(negedge Clk);
        g_req = 1'b0;
        ref_mem[2][4] = 16'h1234;
        checks++; if (gnt_at !== 12) begin failures++; $display("FAIL collide_gnt: granted at %0d want 12", gnt_at); end
        checks++; if (we_early !== 1'b0 || ok_at_gnt !== 1'b1) begin failures++; $display("FAIL collide_mem: early_we %b access_ok %b want 0/1", we_early, ok_at_gnt); end
        checks++; if (Row !== exp_row(7)) begin failures++; $display("FAIL collide_row7: got %h want %h", Row, exp_row(7)); end
    endtask

    task automatic test_pending();
        int r1 = -1, r2 = -1, pulses = 0;
        logic row3_ok = 1'b0, row5_ok = 1'b0;
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'd3;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (k == 1) LD_Row = 1'b0;
            if (k == 4) begin LD_Row = 1'b1; rowNum = 8'd5; end
            if (k == 5) LD_Row = 1'b0;
            if (rowReady === 1'b1) begin
                pulses++;
                if (pulses == 1) begin r1 = k; row3_ok = (Row === exp_row(3)); end
                if (pulses == 2) begin r2 = k; row5_ok = (Row === exp_row(5)); end
            end
        end
        checks++; if (r1 !== 12 || r2 !== 25) begin failures++; $display("FAIL pend_timing: ready at %0d,%0d want 12,25", r1, r2); end
        checks++; if (row3_ok !== 1'b1 || row5_ok !== 1'b1) begin failures++; $display("FAIL pend_rows: row3 %b row5 %b want 1/1", row3_ok, row5_ok); end
        checks++; if (pulses !== 2) begin failures++; $display("FAIL pend_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_pend_overwrite();
        int pulses = 0, last = -1;
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'd1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (k == 1 || k == 4 || k == 7) LD_Row = 1'b0;
            if (k == 3) begin LD_Row = 1'b1; rowNum = 8'd6; end
            if (k == 6) begin LD_Row = 1'b1; rowNum = 8'd9; end
            if (rowReady === 1'b1) begin pulses++; last = k; end
        end
        checks++; if (pulses !== 2 || last !== 25) begin failures++; $display("FAIL pend_overwrite: pulses %0d last %0d want 2/25", pulses, last); end
        checks++; if (Row !== exp_row(9)) begin failures++; $display("FAIL pend_overwrite_row: got %h want %h", Row, exp_row(9)); end
    endtask

    task automatic test_oor_row();
        int lat; logic ok;
        do_fetch(2, lat, ok);
        do_fetch(20, lat, ok);
        checks++; if (lat !== 2) begin failures++; $display("FAIL oor_latency: got %0d want 2", lat); end
        checks++; if (Row !== '0) begin failures++; $display("FAIL oor_row: got %h want 0", Row); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL oor_addr: board address issued, ok %b want 1", ok); end
    endtask

    task automatic test_reset_mid();
        int lat; logic ok; int pulses = 0;
        do_fetch(11, lat, ok);
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'd4;
        for (int k = 1; k <= 25; k++) begin
            @(negedge Clk);
            if (k == 1) LD_Row = 1'b0;
            if (k == 6) reset = 1'b1;
            if (k == 7) reset = 1'b0;
            if (rowReady === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_mid_pulse: got %0d want 0", pulses); end
        checks++; if (Row !== '0) begin failures++; $display("FAIL reset_mid_row: got %h want 0", Row); end
    endtask

    task automatic test_random();
        int op, r, c, wt, lat;
        logic rv, ok;
        logic [DW-1:0] d, rd, exp_d;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                r = $urandom_range(0, 23); c = $urandom_range(0, 11); d = DW'($urandom);
                do_game(1'b1, r, c, d, wt, rv, rd);
                if (r < ROWS && c < COLS) ref_mem[r][c] = d;
                checks++; if (wt !== 0) begin failures++; $display("FAIL rand_write_gnt: wait %0d want 0", wt); end
            end else if (op == 1) begin
                r = $urandom_range(0, 23); c = $urandom_range(0, 11);
                exp_d = (r < ROWS && c < COLS) ? ref_mem[r][c] : '0;
                do_game(1'b0, r, c, 16'h0, wt, rv, rd);
                checks++; if (wt !== 0 || rv !== 1'b1 || rd !== exp_d)
                    begin failures++; $display("FAIL rand_read r%0d c%0d: wait %0d rvalid %b data %h want 0/1/%h", r, c, wt, rv, rd, exp_d); end
            end else begin
                r = $urandom_range(0, 21);
                do_fetch(r, lat, ok);
                checks++; if (lat !== ((r < ROWS) ? 12 : 2) || ok !== 1'b1 || Row !== exp_row(r))
                    begin failures++; $display("FAIL rand_fetch r%0d: lat %0d addr_ok %b row %h want %h", r, lat, ok, Row, exp_row(r)); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; load_ram = 1'b1;
        LD_Row = 1'b0; rowNum = '0;
        g_req = 1'b0; g_we = 1'b0; g_row = '0; g_col = '0; g_wdata = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ref_mem[r][c] = {8'(r), 8'(c)};
        test_reset();
        test_row_fetch();
        test_hold();
        test_game_rw();
        test_collision();
        test_pending();
        test_pend_overwrite();
        test_oor_row();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
